// File: rtl/return_scheduler.sv
// rtl/return_scheduler.sv - in-order tag allocation and round-robin return sequencing for write/read classes
// Optional feature macro: RET_TIMEOUT_EN (per-class head age watchdog driving timeout)
module return_scheduler #(
  parameter int NUM_SLOTS   = 8,
  parameter int TAG_W       = $clog2(NUM_SLOTS),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_alloc_req,
  output logic             wr_alloc_gnt,
  output logic [TAG_W-1:0] wr_alloc_tag,
  input  logic             rd_alloc_req,
  output logic             rd_alloc_gnt,
  output logic [TAG_W-1:0] rd_alloc_tag,
  input  logic             wr_cmpl_valid,
  input  logic [TAG_W-1:0] wr_cmpl_tag,
  input  logic             rd_cmpl_valid,
  input  logic [TAG_W-1:0] rd_cmpl_tag,
  input  logic             ret_ready,
  output logic             wd,
  output logic             rd,
  output logic [31:0]      data,
  output logic [TAG_W:0]   wr_outstanding,
  output logic [TAG_W:0]   rd_outstanding,
  output logic             err_cmpl,
  output logic             timeout
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NUM_SLOTS);

  typedef enum logic {IDLE, PRESENT} state_t;

  // class index 0 = write, 1 = read
  logic [TAG_W-1:0]     alloc_ptr [2];
  logic [TAG_W-1:0]     head_ptr  [2];
  logic [TAG_W:0]       count     [2];
  logic [NUM_SLOTS-1:0] done      [2];
  logic [15:0]          seq       [2];

  state_t state;
  logic   cur_cls;
  logic   last_served;

  logic [1:0]       req, cmpl_v, gnt, ok, err, elig, retire;
  logic [TAG_W-1:0] cmpl_tag [2];
  logic [TAG_W-1:0] offset   [2];
  logic             pick_rd;

  assign req         = {rd_alloc_req, wr_alloc_req};
  assign cmpl_v      = {rd_cmpl_valid, wr_cmpl_valid};
  assign cmpl_tag[0] = wr_cmpl_tag;
  assign cmpl_tag[1] = rd_cmpl_tag;

  for (genvar c = 0; c < 2; c++) begin : g_cls
    // a tag is live when its distance from head is below the occupancy
    assign gnt[c]    = req[c] & (count[c] != FULL);
    assign offset[c] = cmpl_tag[c] - head_ptr[c];
    assign ok[c]     = cmpl_v[c] & ({1'b0, offset[c]} < count[c]) & ~done[c][cmpl_tag[c]];
    assign err[c]    = cmpl_v[c] & ~ok[c];
    assign elig[c]   = (count[c] != '0) & done[c][head_ptr[c]];
    assign retire[c] = (state == PRESENT) & ret_ready & (cur_cls == 1'(c));
  end

  // on a tie the class not served last wins
  assign pick_rd = elig[1] & (~elig[0] | ~last_served);

  assign wr_alloc_gnt   = gnt[0];
  assign rd_alloc_gnt   = gnt[1];
  assign wr_alloc_tag   = alloc_ptr[0];
  assign rd_alloc_tag   = alloc_ptr[1];
  assign wr_outstanding = count[0];
  assign rd_outstanding = count[1];

  // per-class pointers, occupancy, done bitmaps and return sequence numbers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        alloc_ptr[c] <= '0;
        head_ptr[c]  <= '0;
        count[c]     <= '0;
        done[c]      <= '0;
        seq[c]       <= '0;
      end
      err_cmpl <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (gnt[c])
          alloc_ptr[c] <= alloc_ptr[c] + 1'b1;
        if (ok[c])
          done[c][cmpl_tag[c]] <= 1'b1;
        if (retire[c]) begin
          done[c][head_ptr[c]] <= 1'b0;
          head_ptr[c]          <= head_ptr[c] + 1'b1;
          seq[c]               <= seq[c] + 16'd1;
        end
        count[c] <= count[c] + (TAG_W+1)'(gnt[c]) - (TAG_W+1)'(retire[c]);
      end
      err_cmpl <= |err;
    end
  end

  // return channel FSM: select an eligible head, present it, retire on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cur_cls     <= 1'b0;
      last_served <= 1'b1;
      wd          <= 1'b0;
      rd          <= 1'b0;
      data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (elig != 2'b00) begin
            cur_cls <= pick_rd;
            wd      <= ~pick_rd;
            rd      <= pick_rd;
            data    <= {pick_rd, 7'b0, 8'(head_ptr[pick_rd]), seq[pick_rd]};
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (ret_ready) begin
            wd          <= 1'b0;
            rd          <= 1'b0;
            last_served <= cur_cls;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RET_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] age [2];
  logic [1:0]  aging, hit;

  for (genvar c = 0; c < 2; c++) begin : g_age
    assign aging[c] = ~retire[c] & (count[c] != '0) & ~done[c][head_ptr[c]];
    assign hit[c]   = aging[c] & (age[c] == TO_LAST);
  end

  // head age counters; saturate at the limit so the flag cannot be missed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age[0]  <= '0;
      age[1]  <= '0;
      timeout <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (retire[c] || count[c] == '0)
          age[c] <= '0;
        else if (aging[c] && age[c] != 16'(TIMEOUT_CYC))
          age[c] <= age[c] + 16'd1;
      end
      timeout <= timeout | (|hit);
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_return_scheduler.sv
// tb/tb_return_scheduler.sv - directed self-checking bench for return_scheduler
module tb_return_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_alloc_req = 1'b0, rd_alloc_req = 1'b0;
  logic        wr_alloc_gnt, rd_alloc_gnt;
  logic [2:0]  wr_alloc_tag, rd_alloc_tag;
  logic        wr_cmpl_valid = 1'b0, rd_cmpl_valid = 1'b0;
  logic [2:0]  wr_cmpl_tag = '0, rd_cmpl_tag = '0;
  logic        ret_ready = 1'b0;
  logic        wd, rd;
  logic [31:0] data;
  logic [3:0]  wr_outstanding, rd_outstanding;
  logic        err_cmpl, timeout;

  int n_checks = 0;
  int n_pass   = 0;

  return_scheduler #(.NUM_SLOTS(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .wr_alloc_req(wr_alloc_req), .wr_alloc_gnt(wr_alloc_gnt), .wr_alloc_tag(wr_alloc_tag),
    .rd_alloc_req(rd_alloc_req), .rd_alloc_gnt(rd_alloc_gnt), .rd_alloc_tag(rd_alloc_tag),
    .wr_cmpl_valid(wr_cmpl_valid), .wr_cmpl_tag(wr_cmpl_tag),
    .rd_cmpl_valid(rd_cmpl_valid), .rd_cmpl_tag(rd_cmpl_tag),
    .ret_ready(ret_ready), .wd(wd), .rd(rd), .data(data),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .err_cmpl(err_cmpl), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    wr_alloc_req = 0; rd_alloc_req = 0; wr_cmpl_valid = 0; rd_cmpl_valid = 0; ret_ready = 0;
    step();
    rst = 1'b1;
  endtask

  task automatic alloc(input bit is_rd, input int n, input int first);
    for (int i = 0; i < n; i++) begin
      if (is_rd) rd_alloc_req = 1'b1; else wr_alloc_req = 1'b1;
      #1;
      chk(is_rd ? "rd_gnt" : "wr_gnt", is_rd ? rd_alloc_gnt : wr_alloc_gnt, 1);
      chk(is_rd ? "rd_tag" : "wr_tag", is_rd ? rd_alloc_tag : wr_alloc_tag, 32'((first + i) % 8));
      step();
    end
    wr_alloc_req = 1'b0;
    rd_alloc_req = 1'b0;
  endtask

  task automatic cmpl(input bit is_rd, input int tag);
    if (is_rd) begin rd_cmpl_valid = 1'b1; rd_cmpl_tag = 3'(tag); end
    else begin wr_cmpl_valid = 1'b1; wr_cmpl_tag = 3'(tag); end
    step();
    wr_cmpl_valid = 1'b0;
    rd_cmpl_valid = 1'b0;
  endtask

  // bounded wait for a return, check it, then handshake it
  task automatic take_ret(input string tag, input bit exp_rd, input logic [31:0] exp_data);
    int i;
    for (i = 0; i < 20 && !(wd || rd); i++) step();
    chk({tag, "_seen"}, 32'(wd | rd), 1);
    chk({tag, "_wd"}, 32'(wd), 32'(!exp_rd));
    chk({tag, "_rd"}, 32'(rd), 32'(exp_rd));
    chk({tag, "_data"}, data, exp_data);
    ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
    chk({tag, "_drop"}, 32'(wd | rd), 0);
  endtask

  initial begin
    bit stable;

    // reset state
    #2;
    chk("rst_wd", 32'(wd), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_data", data, 0);
    chk("rst_err", 32'(err_cmpl), 0);
    chk("rst_timeout", 32'(timeout), 0);
    do_reset();

    // first return latency and outstanding count
    alloc(0, 3, 0);
    chk("wr_out3", 32'(wr_outstanding), 3);
    cmpl(0, 0);
    chk("lat_early", 32'(wd), 0);
    step();
    chk("lat_wd", 32'(wd), 1);
    chk("lat_data", data, 32'h0000_0000);
    ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
    chk("ret_wd_low", 32'(wd), 0);
    chk("wr_out2", 32'(wr_outstanding), 2);

    // out-of-order completion retires in order
    do_reset();
    alloc(0, 2, 0);
    cmpl(0, 1);
    step(); step(); step();
    chk("ooo_hold", 32'(wd), 0);
    cmpl(0, 0);
    take_ret("ooo0", 0, 32'h0000_0000);
    take_ret("ooo1", 0, 32'h0001_0001);
    chk("ooo_out0", 32'(wr_outstanding), 0);

    // round-robin on repeated ties, write wins first
    do_reset();
    alloc(0, 2, 0);
    alloc(1, 2, 0);
    wr_cmpl_valid = 1; wr_cmpl_tag = 0; rd_cmpl_valid = 1; rd_cmpl_tag = 0;
    step();
    wr_cmpl_tag = 1; rd_cmpl_tag = 1;
    step();
    wr_cmpl_valid = 0; rd_cmpl_valid = 0;
    take_ret("rr_w0", 0, 32'h0000_0000);
    take_ret("rr_r0", 1, 32'h8000_0000);
    take_ret("rr_w1", 0, 32'h0001_0001);
    take_ret("rr_r1", 1, 32'h8001_0001);

    // full read class, then wrap after one retire
    do_reset();
    alloc(1, 8, 0);
    rd_alloc_req = 1'b1;
    #1;
    chk("full_gnt", 32'(rd_alloc_gnt), 0);
    chk("full_out", 32'(rd_outstanding), 8);
    step();
    rd_alloc_req = 1'b0;
    chk("full_out_hold", 32'(rd_outstanding), 8);
    cmpl(1, 0);
    take_ret("full_r0", 1, 32'h8000_0000);
    chk("full_out7", 32'(rd_outstanding), 7);
    alloc(1, 1, 0);
    chk("wrap_out8", 32'(rd_outstanding), 8);

    // illegal completions
    do_reset();
    cmpl(0, 5);
    chk("err_unalloc", 32'(err_cmpl), 1);
    step();
    chk("err_pulse_end", 32'(err_cmpl), 0);
    alloc(0, 1, 0);
    cmpl(0, 0);
    chk("err_legal", 32'(err_cmpl), 0);
    step();
    cmpl(0, 0);
    chk("err_dup", 32'(err_cmpl), 1);
    step();
    chk("err_dup_end", 32'(err_cmpl), 0);
    wr_cmpl_valid = 1; wr_cmpl_tag = 3; rd_cmpl_valid = 1; rd_cmpl_tag = 3;
    step();
    wr_cmpl_valid = 0; rd_cmpl_valid = 0;
    chk("err_both", 32'(err_cmpl), 1);
    step();
    chk("err_both_end", 32'(err_cmpl), 0);
    take_ret("err_ret0", 0, 32'h0000_0000);
    step(); step(); step();
    chk("err_no_extra", 32'(wd | rd), 0);
    chk("err_out0", 32'(wr_outstanding), 0);

    // hold during backpressure, then asynchronous reset mid-hold
    do_reset();
    alloc(0, 2, 0);
    cmpl(0, 0);
    take_ret("hold_r0", 0, 32'h0000_0000);
    cmpl(0, 1);
    step();
    chk("hold_wd", 32'(wd), 1);
    chk("hold_data", data, 32'h0001_0001);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wd !== 1'b1 || data !== 32'h0001_0001) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_wd", 32'(wd), 0);
    chk("arst_data", data, 0);
    chk("arst_out", 32'(wr_outstanding), 0);
    step();
    rst = 1'b1;
    step(); step();
    chk("arst_no_ret", 32'(wd | rd), 0);

`ifdef RET_TIMEOUT_EN
    do_reset();
    alloc(0, 1, 0);
    for (int i = 0; i < 15; i++) step();
    chk("to_before", 32'(timeout), 0);
    step();
    chk("to_set", 32'(timeout), 1);
    cmpl(0, 0);
    take_ret("to_ret", 0, 32'h0000_0000);
    chk("to_sticky", 32'(timeout), 1);
`else
    do_reset();
    alloc(0, 1, 0);
    for (int i = 0; i < 40; i++) step();
    chk("to_off", 32'(timeout), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/return_scheduler.md
Name: return_scheduler

Overview:
- Sequences completion returns for the TX controller.
- Allocates in-order tags for write and read transactions and records out-of-order completions per tag in done bitmaps.
- Retires each class strictly in allocation order.
- Shares a single 32-bit return channel (wd/rd/data) between the write and read classes using round-robin arbitration and a valid/ready handshake.

Parameters:
- NUM_SLOTS, 8, tags per class; power of 2, range 2..256.
- TAG_W, $clog2(NUM_SLOTS), tag width (derived, do not override).
- TIMEOUT_CYC, 1024, watchdog limit; used only with RET_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- wr_alloc_req  in  1  request a write tag.
- wr_alloc_gnt  out  1  tag granted this cycle.
- wr_alloc_tag  out  TAG_W  granted write tag.
- rd_alloc_req  in  1  request a read tag.
- rd_alloc_gnt  out  1  tag granted this cycle.
- rd_alloc_tag  out  TAG_W  granted read tag.
- wr_cmpl_valid  in  1  write completion strobe.
- wr_cmpl_tag  in  TAG_W  completed write tag.
- rd_cmpl_valid  in  1  read completion strobe.
- rd_cmpl_tag  in  TAG_W  completed read tag.
- ret_ready  in  1  consumer accepts the return.
- wd  out  1  write return valid.
- rd  out  1  read return valid.
- data  out  32  return word.
- wr_outstanding  out  TAG_W+1  allocated, unretired write tags.
- rd_outstanding  out  TAG_W+1  allocated, unretired read tags.
- err_cmpl  out  1  illegal completion pulse.
- timeout  out  1  sticky watchdog flag (RET_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all pointers/counts/seq 0, done bitmaps 0, state IDLE, last_served=READ (WRITE wins the first tie).
- Per-class state: circular alloc_ptr, head_ptr, count (0..NUM_SLOTS), done[NUM_SLOTS], 16-bit seq.
- Allocation (combinational grant):
  - x_alloc_gnt = x_alloc_req & (count<NUM_SLOTS); x_alloc_tag = alloc_ptr.
  - On grant: alloc_ptr+1 (wraps NUM_SLOTS-1 -> 0), count+1.
  - Full: gnt=0; req is ignored and not queued.
- Completion:
  - Tag is allocated if it lies in [head_ptr, alloc_ptr) modulo NUM_SLOTS, or in any position when count=NUM_SLOTS.
  - If allocated and done=0: set done[tag] at the clock edge.
  - Otherwise (unallocated, or already done): no state change; err_cmpl=1 for exactly one cycle, the cycle after the strobe.
  - A write error and a read error in the same cycle give one pulse.
- Eligibility: class x is eligible when count>0 and done[head_ptr]=1. Completions become visible to eligibility the cycle after the strobe.
- FSM:
  - IDLE: if neither class is eligible, stay. If one is eligible, select it. If both are eligible, select the class != last_served.
    - Register wd/rd (one-hot), data = {is_read, 7'b0, tag zero-extended to 8 bits, seq[15:0]}.
    - Go to PRESENT.
  - PRESENT: hold wd/rd/data stable while ret_ready=0.
    - On ret_ready=1 (handshake): clear done[head], head_ptr+1 (wraps), count-1, seq+1 (wraps 0xFFFF -> 0), last_served=class.
    - Drop wd/rd to 0 next cycle; go to IDLE.
- Throughput: max one return per 2 cycles. Latency from completion strobe of the head tag to wd/rd high is 2 cycles.
- Same-cycle grant and retire in one class: count unchanged, both pointers advance.
- x_outstanding = count, registered.
- A completion for the tag currently presented is impossible (already done) and reports err_cmpl.
- rst asserted mid-handshake: return is dropped, everything is cleared, and no retire is counted.

Optional Feature:
- Macro: RET_TIMEOUT_EN.
- Defined: a per-class 16-bit age counter resets to 0 on head retire and whenever count=0, and otherwise increments each cycle while count>0 and done[head]=0. timeout goes 1 the cycle a counter reaches TIMEOUT_CYC and stays 1 until reset.
- Undefined: no counters; timeout is constant 0.

Test Plan:
- Reset, then allocate write tags 0,1,2; complete tag 0 -> wd=1, data=0x00000000 two cycles later. Hold ret_ready=1 -> retire; wr_outstanding 3 -> 2.
- Allocate write tags 0,1; complete 1 then 0 -> returns in order: data 0x00010001 is not sent first; sequence is 0x00000000 then 0x00010001. wd never high before the tag-0 completion.
- Write and read heads both done simultaneously after reset -> write first (data 0x00000000), then read (data 0x80000000), then alternates on repeated ties.
- Allocate 8 read tags -> 9th rd_alloc_req gets rd_alloc_gnt=0. Retire one -> next grant returns tag 0 (wrap); rd_outstanding stays 8.
- Complete unallocated write tag 5 with count=0, and complete tag 0 twice -> err_cmpl single-cycle pulse each time; no return generated for the illegal ones.
- ret_ready=0 for 10 cycles during PRESENT -> wd and data stable. Assert rst mid-hold -> all outputs 0 immediately; with RET_TIMEOUT_EN and TIMEOUT_CYC=16, an undone head sets timeout after 16 cycles.
